// File: rtl/mem_fetch_if_if.sv
// Memory bus between the fetch stage and the 256x8 RAM.
//   mem_req   : request, held until ack or timeout (master -> slave)
//   mem_we    : write qualifier, valid with mem_req (master -> slave)
//   mem_addr  : access address, stable while mem_req=1 (master -> slave)
//   mem_wdata : write data, stable while mem_req=1 (master -> slave)
//   mem_rdata : read data, valid with mem_ack (slave -> master)
//   mem_ack   : one-cycle completion strobe (slave -> master)
interface mem_fetch_if_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_fetch_if.sv
// Memory-side fetch stage feeding the uOP decoder. Registers each control-unit
// request, runs a req/ack transaction on the RAM bus, returns read data on ibuf
// and aborts hung accesses after TIMEOUT wait cycles, substituting NOP_WORD.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   csel             : access request (level; held high = back-to-back accesses)
//   read_enable      : 1 = read into ibuf, 0 = write wdata
//   addr, wdata      : access address / write data, sampled in IDLE only
//   ibuf, ibuf_valid : last fetched byte, one-cycle update pulse
//   done             : one-cycle pulse when any access finishes
//   busy             : transaction outstanding (combinational from state)
//   err, err_clr     : sticky timeout flag and its synchronous clear
//   mem              : RAM bus, master side
module mem_fetch_if #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          TIMEOUT  = 15,
    parameter logic [DATA_W-1:0]    NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               csel,
    input  logic               read_enable,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  ibuf,
    output logic               ibuf_valid,
    output logic               done,
    output logic               busy,
    output logic               err,
    input  logic               err_clr,
    mem_fetch_if_if.master     mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  ibuf_q, ibuf_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               timeout_hit;

    // Last permitted wait cycle; ack on the same edge takes priority below.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ibuf_q  <= NOP_WORD;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ibuf_q  <= ibuf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ibuf_d  = ibuf_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        // Clear first so a timeout in the same cycle overrides it.
        err_d   = err_q & ~err_clr;

        case (state_q)
            IDLE: begin
                if (csel) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = ~read_enable;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = read_enable ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    if (state_q == RD_WAIT) begin
                        ibuf_d  = mem.mem_rdata;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (state_q == RD_WAIT) begin
                        ibuf_d  = NOP_WORD;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign ibuf          = ibuf_q;
    assign ibuf_valid    = valid_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
